seg7_capture: RTL

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_pkg.sv | 50 +++++
 rtl/seg7_to_hex.sv | 38 +++
 rtl/seg7_capture.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture block: segment codes, bit indices,
// FSM state type and the anode one-hot helpers.
package seg7_pkg;

  // Active-low segment codes, bit order ABCDEFG (bit 6 = A).
  localparam logic [6:0] Seg0     = 7'b0000001;
  localparam logic [6:0] Seg1     = 7'b1001111;
  localparam logic [6:0] Seg2     = 7'b0010010;
  localparam logic [6:0] Seg3     = 7'b0000110;
  localparam logic [6:0] Seg4     = 7'b1001100;
  localparam logic [6:0] Seg5     = 7'b0100100;
  localparam logic [6:0] Seg6     = 7'b0100000;
  localparam logic [6:0] Seg7     = 7'b0001111;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0000100;
  localparam logic [6:0] SegA     = 7'b0001000;
  localparam logic [6:0] SegB     = 7'b1100000;
  localparam logic [6:0] SegC     = 7'b0110001;
  localparam logic [6:0] SegD     = 7'b1000010;
  localparam logic [6:0] SegE     = 7'b0110000;
  localparam logic [6:0] SegF     = 7'b0111000;
  localparam logic [6:0] SegBlank = 7'b1111111;

  localparam int unsigned IdxA = 6;
  localparam int unsigned IdxB = 5;
  localparam int unsigned IdxC = 4;
  localparam int unsigned IdxD = 3;
  localparam int unsigned IdxE = 2;
  localparam int unsigned IdxF = 1;
  localparam int unsigned IdxG = 0;

  typedef enum logic [0:0] {StCollect, StPublish} state_e;

  // True when exactly one anode line is driven low.
  function automatic logic onehot_low(input logic [3:0] an);
    logic [3:0] act;
    act = ~an;
    return (act != 4'b0000) && ((act & (act - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decoder from an active-low ABCDEFG segment pattern to a hex nibble,
// flagging the all-off blank pattern and any unrecognized code.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg7,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    nibble  = 4'h0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (seg7)
      Seg0:     nibble = 4'h0;
      Seg1:     nibble = 4'h1;
      Seg2:     nibble = 4'h2;
      Seg3:     nibble = 4'h3;
      Seg4:     nibble = 4'h4;
      Seg5:     nibble = 4'h5;
      Seg6:     nibble = 4'h6;
      Seg7:     nibble = 4'h7;
      Seg8:     nibble = 4'h8;
      Seg9:     nibble = 4'h9;
      SegA:     nibble = 4'hA;
      SegB:     nibble = 4'hB;
      SegC:     nibble = 4'hC;
      SegD:     nibble = 4'hD;
      SegE:     nibble = 4'hE;
      SegF:     nibble = 4'hF;
      SegBlank: blank  = 1'b1;
      default:  invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Snoops a multiplexed 4-digit seven-segment display bus and reconstructs the shown
// 16-bit hex value once every digit has been seen stable for SETTLE cycles.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg7,
  output logic [15:0] hex_out,
  output logic [3:0]  blank_mask,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stale
);

  localparam int unsigned TW         = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  SettleCnt  = 8'(SETTLE);
  localparam logic [TW-1:0] TimeoutCnt = TW'(TIMEOUT);

  logic [3:0]      an_meta_q, an_sync_q;
  logic [6:0]      seg_meta_q, seg_sync_q;
  logic [10:0]     prev_q;
  logic [7:0]      cnt_q, cnt_d;
  logic            changed, capture;
  logic [1:0]      cap_idx;
  logic [3:0]      dec_nib;
  logic            dec_blank, dec_inv;
  logic [3:0][3:0] nib_q, nib_d;
  logic [3:0]      blank_q, blank_d, inv_q, inv_d, seen_q, seen_d;
  state_e          state_q, state_d;
  logic            publish_ok, publish_err;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            stale_q, stale_d;
  logic [15:0]     hex_q;
  logic [3:0]      blank_mask_q;
  logic            frame_valid_q, frame_err_q;

  seg7_to_hex u_dec (
    .seg7    (seg_sync_q),
    .nibble  (dec_nib),
    .blank   (dec_blank),
    .invalid (dec_inv)
  );

  // Capture fires only on the cycle the stability count first lands on SETTLE.
  always_comb begin
    changed = {an_sync_q, seg_sync_q} != prev_q;
    if (changed)                cnt_d = 8'd1;
    else if (cnt_q == SettleCnt) cnt_d = cnt_q;
    else                        cnt_d = cnt_q + 8'd1;
    capture = (cnt_d == SettleCnt) && (changed || (cnt_q != SettleCnt)) &&
              onehot_low(an_sync_q);
    cap_idx = low_index(an_sync_q);
  end

  always_comb begin
    nib_d   = nib_q;
    blank_d = blank_q;
    inv_d   = inv_q;
    seen_d  = (state_q == StPublish) ? 4'b0000 : seen_q;
    if (capture) begin
      nib_d[cap_idx]   = dec_nib;
      blank_d[cap_idx] = dec_blank;
      inv_d[cap_idx]   = dec_inv;
      seen_d[cap_idx]  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StCollect;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (seen_q == 4'b1111) state_d = StPublish;
      StPublish: state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  always_comb begin
    publish_ok  = (state_q == StPublish) && (inv_q == 4'b0000);
    publish_err = (state_q == StPublish) && (inv_q != 4'b0000);
  end

  always_comb begin
    if (publish_ok)               tmo_d = '0;
    else if (tmo_q == TimeoutCnt) tmo_d = tmo_q;
    else                          tmo_d = tmo_q + TW'(1);
    if (publish_ok)               stale_d = 1'b0;
    else if (tmo_d == TimeoutCnt) stale_d = 1'b1;
    else                          stale_d = stale_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_meta_q     <= '0;
      an_sync_q     <= '0;
      seg_meta_q    <= '0;
      seg_sync_q    <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      nib_q         <= '0;
      blank_q       <= '0;
      inv_q         <= '0;
      seen_q        <= '0;
      tmo_q         <= '0;
      stale_q       <= 1'b1;
      hex_q         <= '0;
      blank_mask_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      an_meta_q     <= an;
      an_sync_q     <= an_meta_q;
      seg_meta_q    <= seg7;
      seg_sync_q    <= seg_meta_q;
      prev_q        <= {an_sync_q, seg_sync_q};
      cnt_q         <= cnt_d;
      nib_q         <= nib_d;
      blank_q       <= blank_d;
      inv_q         <= inv_d;
      seen_q        <= seen_d;
      tmo_q         <= tmo_d;
      stale_q       <= stale_d;
      frame_valid_q <= publish_ok;
      frame_err_q   <= publish_err;
      if (publish_ok) begin
        hex_q        <= nib_q;
        blank_mask_q <= blank_q;
      end
    end
  end

  assign hex_out     = hex_q;
  assign blank_mask  = blank_mask_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign stale       = stale_q;

endmodule
